arbiter_round_robin_hold: RTL and testbench

Registered round-robin arbiter over `WORD_WIDTH` requestors, built around thermometer-mask priority rotation: the last-issued one-hot grant is turned into a mask that passes only more-significant requestors. A grant is held for as long as its requestor keeps requesting. It sits upstream of shared-resource multiplexers, which consume its one-hot `grant` and binary `grant_index` directly as select lines.

---
 rtl/arbiter_round_robin_hold_if.sv | 28 ++
 rtl/arbiter_round_robin_hold.sv | 92 +++++++++
 tb/tb_arbiter_round_robin_hold.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/arbiter_round_robin_hold_if.sv
// Request/grant bundle between requestors and the round-robin arbiter.
// The master side is the arbiter, which drives the grant outputs.
interface arbiter_round_robin_hold_if #(
    parameter int WORD_WIDTH  = 4,
    parameter int INDEX_WIDTH = $clog2(WORD_WIDTH)
);
    logic [WORD_WIDTH-1:0]  requests;
    logic [WORD_WIDTH-1:0]  grant;
    logic                   grant_valid;
    logic [INDEX_WIDTH-1:0] grant_index;
    logic                   grant_changed;

    modport master (
        input  requests,
        output grant,
        output grant_valid,
        output grant_index,
        output grant_changed
    );

    modport slave (
        output requests,
        input  grant,
        input  grant_valid,
        input  grant_index,
        input  grant_changed
    );
endinterface

// File: rtl/arbiter_round_robin_hold.sv
// Registered round-robin arbiter with grant hold: a thermometer mask built from the
// last issued grant gives priority to more-significant requestors, then wraps to bit 0.
module arbiter_round_robin_hold #(
    parameter int WORD_WIDTH  = 4,
    parameter int INDEX_WIDTH = $clog2(WORD_WIDTH)
) (
    input  logic                        clock,
    input  logic                        reset,
    arbiter_round_robin_hold_if.master  bus
);
    localparam logic [WORD_WIDTH-1:0] ONE = WORD_WIDTH'(1);
    localparam logic [WORD_WIDTH-1:0] MSB = ONE << (WORD_WIDTH - 1);

    logic [WORD_WIDTH-1:0]  grant_reg;
    logic [WORD_WIDTH-1:0]  last_grant_reg;
    logic                   grant_valid_reg;
    logic [INDEX_WIDTH-1:0] grant_index_reg;
    logic                   grant_changed_reg;

    logic [WORD_WIDTH-1:0]  requests;
    logic [WORD_WIDTH-1:0]  mask;
    logic [WORD_WIDTH-1:0]  masked_requests;
    logic [WORD_WIDTH-1:0]  masked_pick;
    logic [WORD_WIDTH-1:0]  wrap_pick;
    logic                   hold;
    logic [WORD_WIDTH-1:0]  grant_next;
    logic [WORD_WIDTH-1:0]  last_grant_next;
    logic                   grant_changed_next;
    logic [INDEX_WIDTH-1:0] grant_index_next;
    logic [INDEX_WIDTH-1:0] index_terms [WORD_WIDTH];

    assign requests = bus.requests;

    // last_grant is never zero, so the subtraction never wraps.
    assign mask            = ~(last_grant_reg ^ (last_grant_reg - ONE));
    assign masked_requests = requests & mask;
    assign masked_pick     = masked_requests & (~masked_requests + ONE);
    assign wrap_pick       = requests & (~requests + ONE);
    assign hold            = |(grant_reg & requests);

    always_comb begin
        grant_next         = grant_reg;
        last_grant_next    = last_grant_reg;
        grant_changed_next = 1'b0;
        if (hold) begin
            grant_next = grant_reg;
        end else if (|masked_requests) begin
            grant_next         = masked_pick;
            last_grant_next    = masked_pick;
            grant_changed_next = (masked_pick != grant_reg);
        end else if (|requests) begin
            grant_next         = wrap_pick;
            last_grant_next    = wrap_pick;
            grant_changed_next = (wrap_pick != grant_reg);
        end else begin
            grant_next = '0;
        end
    end

    // One-hot to binary: each set bit contributes its own position.
    for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_index
        assign index_terms[gi] = grant_next[gi] ? INDEX_WIDTH'(gi) : '0;
    end

    always_comb begin
        grant_index_next = '0;
        for (int i = 0; i < WORD_WIDTH; i++) begin
            grant_index_next = grant_index_next | index_terms[i];
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            grant_reg         <= '0;
            last_grant_reg    <= MSB;
            grant_valid_reg   <= 1'b0;
            grant_index_reg   <= '0;
            grant_changed_reg <= 1'b0;
        end else begin
            grant_reg         <= grant_next;
            last_grant_reg    <= last_grant_next;
            grant_valid_reg   <= |grant_next;
            grant_index_reg   <= grant_index_next;
            grant_changed_reg <= grant_changed_next;
        end
    end

    assign bus.grant         = grant_reg;
    assign bus.grant_valid   = grant_valid_reg;
    assign bus.grant_index   = grant_index_reg;
    assign bus.grant_changed = grant_changed_reg;
endmodule

// File: tb/tb_arbiter_round_robin_hold.sv
// Directed bench for arbiter_round_robin_hold: a circular-search round-robin model
// checked every cycle, plus hand-computed literal expectations.
module tb_arbiter_round_robin_hold;
    localparam int W = 4;

    logic         clock;
    logic         reset;
    logic [W-1:0] requests;

    int checks = 0;
    int errors = 0;

    // Model state as plain integer indices; -1 means no grant.
    int m_grant   = -1;
    int m_last    = W - 1;
    int m_pick    = -1;
    bit m_changed = 1'b0;

    arbiter_round_robin_hold_if #(.WORD_WIDTH(W)) bus ();

    assign bus.requests = requests;

    arbiter_round_robin_hold #(.WORD_WIDTH(W)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Round robin: keep a still-requested grant, otherwise search circularly
    // starting just above the last issued grant.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_grant   = -1;
            m_last    = W - 1;
            m_changed = 1'b0;
        end else begin
            m_changed = 1'b0;
            if (!(m_grant >= 0 && requests[m_grant])) begin
                m_pick = -1;
                for (int k = 1; k <= W; k++) begin
                    if (m_pick < 0 && requests[(m_last + k) % W]) m_pick = (m_last + k) % W;
                end
                if (m_pick >= 0) begin
                    m_changed = (m_pick != m_grant);
                    m_grant   = m_pick;
                    m_last    = m_pick;
                end else begin
                    m_grant = -1;
                end
            end
        end
    end

    always @(negedge clock) begin
        logic [W-1:0] eg;
        logic [1:0]   ei;
        if (!reset) begin
            eg = (m_grant >= 0) ? W'(1 << m_grant) : '0;
            ei = (m_grant >= 0) ? 2'(m_grant) : 2'd0;
            checks++;
            if (bus.grant !== eg || bus.grant_index !== ei ||
                bus.grant_valid !== (m_grant >= 0) || bus.grant_changed !== m_changed) begin
                errors++;
                $display("FAIL model_cycle t=%0t: got grant=%b idx=%0d valid=%b changed=%b, expected grant=%b idx=%0d valid=%b changed=%b",
                         $time, bus.grant, bus.grant_index, bus.grant_valid, bus.grant_changed,
                         eg, ei, (m_grant >= 0), m_changed);
            end
        end
    end

    task automatic check_out(input string name, input logic [W-1:0] g, input logic [1:0] idx,
                             input logic v, input logic ch);
        checks++;
        if (bus.grant !== g || bus.grant_index !== idx || bus.grant_valid !== v || bus.grant_changed !== ch) begin
            errors++;
            $display("FAIL %s: got grant=%b idx=%0d valid=%b changed=%b, expected grant=%b idx=%0d valid=%b changed=%b",
                     name, bus.grant, bus.grant_index, bus.grant_valid, bus.grant_changed, g, idx, v, ch);
        end
    endtask

    // Apply requests for one edge; outputs are sampled 2 time units after it.
    task automatic cycle(input logic [W-1:0] req);
        requests = req;
        @(posedge clock);
        #2;
        $display("req=%b grant=%b idx=%0d valid=%b changed=%b",
                 req, bus.grant, bus.grant_index, bus.grant_valid, bus.grant_changed);
    endtask

    initial begin
        reset    = 1'b1;
        requests = 4'b1111;
        repeat (3) @(posedge clock);
        #2;
        check_out("reset_outputs", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;

        cycle(4'b1111);
        check_out("first_grant", 4'b0001, 2'd0, 1'b1, 1'b1);
        cycle(4'b1111);
        check_out("first_grant_pulse_end", 4'b0001, 2'd0, 1'b1, 1'b0);

        for (int i = 0; i < 6; i++) begin
            cycle(4'b0101);
            check_out("hold_0101", 4'b0001, 2'd0, 1'b1, 1'b0);
        end

        cycle(4'b1110);
        check_out("rot_1", 4'b0010, 2'd1, 1'b1, 1'b1);
        cycle(4'b1101);
        check_out("rot_2", 4'b0100, 2'd2, 1'b1, 1'b1);
        cycle(4'b1011);
        check_out("rot_3", 4'b1000, 2'd3, 1'b1, 1'b1);
        cycle(4'b0111);
        check_out("rot_wrap", 4'b0001, 2'd0, 1'b1, 1'b1);

        cycle(4'b0100);
        check_out("set_last_0100", 4'b0100, 2'd2, 1'b1, 1'b1);
        cycle(4'b0011);
        check_out("wrap_pick", 4'b0001, 2'd0, 1'b1, 1'b1);
        cycle(4'b0010);
        check_out("set_last_0010", 4'b0010, 2'd1, 1'b1, 1'b1);
        cycle(4'b1001);
        check_out("masked_pick", 4'b1000, 2'd3, 1'b1, 1'b1);

        cycle(4'b0010);
        check_out("msb_wraps_to_0010", 4'b0010, 2'd1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(4'b0000);
            check_out("idle", 4'b0000, 2'd0, 1'b0, 1'b0);
        end
        cycle(4'b0110);
        check_out("idle_retention", 4'b0100, 2'd2, 1'b1, 1'b1);

        requests = 4'b1001;
        #1 reset = 1'b1;
        #1;
        check_out("async_reset_mid_grant", 4'b0000, 2'd0, 1'b0, 1'b0);
        reset = 1'b0;
        @(posedge clock);
        #2;
        check_out("after_reset_grant", 4'b0001, 2'd0, 1'b1, 1'b1);
        cycle(4'b1001);
        check_out("after_reset_hold", 4'b0001, 2'd0, 1'b1, 1'b0);

        @(negedge clock);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
